// File: rtl/apu_stim_gen.sv
// apu_stim_gen: operand/transaction generator for APU cluster bring-up and emulation.
//
// Each operand lane runs its own Galois LFSR. The lane value is constrained so that it is never
// Inf/NaN: an all-ones exponent loses its top bit. For SQRT_OP, lane 0 is also forced positive.
// The block issues a programmed number of tagged requests. It keeps the outstanding tags and
// their issue timestamps in an in-order FIFO. It counts tag errors and spurious responses, and
// it records the worst-case grant-to-response latency of the run.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              start a run (honoured in IDLE/DONE only)
//   num_trans_i, op_i    transactions per run and op code, latched at start
//   req_o, gnt_i         request handshake
//   operands_o           NUM_OPERANDS lanes of WIDTH bits, lane 0 (a) at the LSBs
//   op_o, tag_o          registered op code and current transaction tag
//   rvalid_i, rtag_i     response valid and response tag
//   busy_o, done_o       run in progress / run finished (level)
//   issued_o             accepted transactions this run
//   err_cnt_o            tag mismatches plus spurious responses (saturating)
//   max_lat_o            worst grant-to-response latency this run, in cycles
//   timeout_o            watchdog fired
//
// Optional feature: define APU_STIM_TIMEOUT_EN to enable the response watchdog. It counts
// TIMEOUT_CYCLES consecutive cycles with outstanding requests and no response, then flushes
// the FIFO, ends the run and raises timeout_o.
module apu_stim_gen #(
  parameter int unsigned      WIDTH           = 32,
  parameter int unsigned      EXP_BITS        = 8,
  parameter int unsigned      NUM_OPERANDS    = 3,
  parameter logic [WIDTH-1:0] POLY            = WIDTH'(32'h80200003),
  parameter logic [31:0]      SEED            = 32'hACE11234,
  parameter int unsigned      MAX_OUTSTANDING = 4,
  parameter int unsigned      TAG_WIDTH       = 4,
  parameter int unsigned      SQRT_OP         = 5,
  parameter int unsigned      TIMEOUT_CYCLES  = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [15:0]                   num_trans_i,
  input  logic [2:0]                    op_i,
  output logic                          req_o,
  input  logic                          gnt_i,
  output logic [NUM_OPERANDS*WIDTH-1:0] operands_o,
  output logic [2:0]                    op_o,
  output logic [TAG_WIDTH-1:0]          tag_o,
  input  logic                          rvalid_i,
  input  logic [TAG_WIDTH-1:0]          rtag_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [15:0]                   issued_o,
  output logic [15:0]                   err_cnt_o,
  output logic [15:0]                   max_lat_o,
  output logic                          timeout_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [15:0]          issued_q, issued_d;
  logic [15:0]          num_q, num_d;
  logic [2:0]           op_q, op_d;
  logic [15:0]          err_q, err_d;
  logic [15:0]          max_lat_q, max_lat_d;
  logic [15:0]          cycle_cnt_q;

  logic [TAG_WIDTH-1:0] fifo_tag_q   [MAX_OUTSTANDING];
  logic [15:0]          fifo_stamp_q [MAX_OUTSTANDING];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      cnt_q;

  logic                 busy, idle_like, start_ok;
  logic                 req, push, pop, spurious, bypass, fifo_empty, flush, wd_fire;
  logic [TAG_WIDTH-1:0] head_tag;
  logic [15:0]          head_stamp, lat;

  assign busy       = (state_q == StIssue) || (state_q == StDrain);
  assign idle_like  = (state_q == StIdle) || (state_q == StDone);
  assign start_ok   = start_i && idle_like;
  assign fifo_empty = (cnt_q == '0);
  assign req        = (state_q == StIssue) && (cnt_q < CntW'(MAX_OUTSTANDING));
  assign push       = req && gnt_i;

  // A response in the same cycle as a grant into an empty FIFO retires that grant directly
  // (latency 0); it is not a spurious response.
  assign bypass     = rvalid_i && fifo_empty && push;
  assign pop        = rvalid_i && (!fifo_empty || push);
  assign spurious   = rvalid_i && fifo_empty && !push;
  assign head_tag   = fifo_empty ? tag_q : fifo_tag_q[rd_ptr_q];
  assign head_stamp = fifo_empty ? cycle_cnt_q : fifo_stamp_q[rd_ptr_q];
  assign lat        = cycle_cnt_q - head_stamp;
  assign flush      = wd_fire;

  // Operand lanes
  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_lane
    localparam logic [31:0]      LaneMix  = 32'(k) * 32'h9E3779B9;
    localparam logic [WIDTH-1:0] SeedW    = WIDTH'(SEED ^ LaneMix);
    localparam logic [WIDTH-1:0] LaneSeed = (SeedW == '0) ? WIDTH'(1) : SeedW;

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] val;

    // Steps only on an accepted request, so a stalled request keeps its operands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lfsr_q <= LaneSeed;
      end else if (push) begin
        lfsr_q <= {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? POLY : '0);
      end
    end

    always_comb begin
      val = lfsr_q;
      if (&lfsr_q[WIDTH-2 -: EXP_BITS]) val[WIDTH-2] = 1'b0;
      if ((k == 0) && (op_q == 3'(SQRT_OP))) val[WIDTH-1] = 1'b0;
    end

    assign operands_o[k*WIDTH +: WIDTH] = (state_q == StIssue) ? val : '0;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    issued_d  = issued_q;
    num_d     = num_q;
    op_d      = op_q;
    err_d     = err_q;
    max_lat_d = max_lat_q;

    if (((pop && (rtag_i != head_tag)) || spurious) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
    if (pop && (lat > max_lat_q)) max_lat_d = lat;
    if (push) begin
      tag_d    = tag_q + TAG_WIDTH'(1);
      issued_d = issued_q + 16'd1;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          tag_d     = '0;
          issued_d  = '0;
          err_d     = '0;
          max_lat_d = '0;
          op_d      = op_i;
          num_d     = num_trans_i;
          state_d   = (num_trans_i == 16'd0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (push && ((issued_q + 16'd1) == num_q)) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (wd_fire) state_d = StDone;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      issued_q    <= '0;
      num_q       <= '0;
      op_q        <= '0;
      err_q       <= '0;
      max_lat_q   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      issued_q    <= issued_d;
      num_q       <= num_d;
      op_q        <= op_d;
      err_q       <= err_d;
      max_lat_q   <= max_lat_d;
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  // Outstanding-tag FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_tag_q[i]   <= '0;
        fifo_stamp_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push && !bypass) begin
        fifo_tag_q[wr_ptr_q]   <= tag_q;
        fifo_stamp_q[wr_ptr_q] <= cycle_cnt_q;
        wr_ptr_q <= (wr_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop && !bypass) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

`ifdef APU_STIM_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_q;
  logic           timeout_q;

  assign wd_fire = busy && !fifo_empty && !rvalid_i && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (rvalid_i || fifo_empty || !busy || wd_fire) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else if (start_ok) begin
      timeout_q <= 1'b0;
    end else if (wd_fire) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign req_o     = req;
  assign op_o      = op_q;
  assign tag_o     = tag_q;
  assign busy_o    = busy;
  assign done_o    = (state_q == StDone);
  assign issued_o  = issued_q;
  assign err_cnt_o = err_q;
  assign max_lat_o = max_lat_q;

endmodule

// File: tb/tb_apu_stim_gen.sv
// Directed bench for apu_stim_gen with hand-computed expected values.
module tb_apu_stim_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_trans;
  logic [2:0]  op;
  logic        gnt;
  logic        rvalid;
  logic [3:0]  rtag;

  logic        req, busy, done, timeout;
  logic [95:0] operands;
  logic [2:0]  op_out;
  logic [3:0]  tag;
  logic [15:0] issued, err_cnt, max_lat;

  // Auxiliary instances with chosen seeds to hit the finite-value constraint
  logic        aux_start;
  logic [15:0] aux_num = 16'd1;
  logic [2:0]  aux_op_plain = 3'd0;
  logic [2:0]  aux_op_sqrt = 3'd5;
  logic        aux_zero = 1'b0;
  logic [3:0]  aux_tag0 = 4'd0;
  logic        inf_req, inf_busy, inf_done, inf_to;
  logic [95:0] inf_ops;
  logic [2:0]  inf_op;
  logic [3:0]  inf_tag;
  logic [15:0] inf_iss, inf_err, inf_lat;
  logic        sq_req, sq_busy, sq_done, sq_to;
  logic [95:0] sq_ops;
  logic [2:0]  sq_op;
  logic [3:0]  sq_tag;
  logic [15:0] sq_iss, sq_err, sq_lat;

  int n_checks = 0;
  int n_pass = 0;
  logic echo_en;
  logic [3:0] grants[$];

  always #5 clk = ~clk;

  apu_stim_gen u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_trans_i(num_trans), .op_i(op),
    .req_o(req), .gnt_i(gnt), .operands_o(operands), .op_o(op_out), .tag_o(tag),
    .rvalid_i(rvalid), .rtag_i(rtag), .busy_o(busy), .done_o(done), .issued_o(issued),
    .err_cnt_o(err_cnt), .max_lat_o(max_lat), .timeout_o(timeout)
  );

  apu_stim_gen #(.SEED(32'h7F800001)) u_inf (
    .clk_i(clk), .rst_ni(rst_n), .start_i(aux_start), .num_trans_i(aux_num),
    .op_i(aux_op_plain), .req_o(inf_req), .gnt_i(aux_zero), .operands_o(inf_ops),
    .op_o(inf_op), .tag_o(inf_tag), .rvalid_i(aux_zero), .rtag_i(aux_tag0), .busy_o(inf_busy),
    .done_o(inf_done), .issued_o(inf_iss), .err_cnt_o(inf_err), .max_lat_o(inf_lat),
    .timeout_o(inf_to)
  );

  apu_stim_gen #(.SEED(32'hC0000000)) u_sqrt (
    .clk_i(clk), .rst_ni(rst_n), .start_i(aux_start), .num_trans_i(aux_num),
    .op_i(aux_op_sqrt), .req_o(sq_req), .gnt_i(aux_zero), .operands_o(sq_ops),
    .op_o(sq_op), .tag_o(sq_tag), .rvalid_i(aux_zero), .rtag_i(aux_tag0), .busy_o(sq_busy),
    .done_o(sq_done), .issued_o(sq_iss), .err_cnt_o(sq_err), .max_lat_o(sq_lat),
    .timeout_o(sq_to)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // One clock; inputs set beforehand apply at the coming edge. With echo enabled, a granted
  // tag is returned on rvalid one cycle after its grant.
  task automatic cyc();
    logic       hs;
    logic [3:0] t;
    hs = req && gnt;
    t  = tag;
    if (hs) grants.push_back(t);
    @(negedge clk);
    if (echo_en) begin
      rvalid = hs;
      rtag   = t;
    end
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done; i++) cyc();
    check("done_reached", 128'(done), 128'(1));
  endtask

  task automatic start_run(input logic [15:0] n, input logic [2:0] o);
    num_trans = n;
    op        = o;
    grants.delete();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_trans = '0; op = '0; gnt = 1'b0;
    rvalid = 1'b0; rtag = '0; echo_en = 1'b0; aux_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 128'(req), 128'(0));
    check("rst_status", 128'({busy, done, timeout}), 128'(0));
    check("rst_counters", 128'({issued, err_cnt, max_lat}), 128'(0));
    check("rst_ops_tag", 128'({operands, tag, op_out}), 128'(0));
    rst_n = 1'b1;
    cyc();

    // Constraint: all-ones exponent and SQRT sign clearing
    aux_start = 1'b1;
    cyc();
    aux_start = 1'b0;
    check("inf_clamp", 128'(inf_ops[31:0]), 128'(32'h3F800001));
    check("sqrt_sign", 128'(sq_ops[31:0]), 128'(32'h40000000));

    // Run A: stalled grant, SQRT op on lane 0
    echo_en = 1'b1;
    gnt = 1'b0;
    start_run(16'd2, 3'd5);
    check("a_req", 128'(req), 128'(1));
    check("a_op", 128'(op_out), 128'(5));
    for (int i = 0; i < 5; i++) begin
      check("stall_ops", 128'(operands), 128'({32'h908FE146, 32'h32D66B8D, 32'h2CE11234}));
      check("stall_tag", 128'(tag), 128'(0));
      cyc();
    end
    gnt = 1'b1;
    cyc();
    check("step_ops", 128'(operands), 128'({32'h4847F0A3, 32'h994B35C5, 32'h5670891A}));
    check("step_tag", 128'(tag), 128'(1));
    cyc();
    check("a_req_low_last", 128'(req), 128'(0));
    check("a_issued", 128'(issued), 128'(2));
    wait_done(20);
    check("a_err", 128'(err_cnt), 128'(0));
    check("a_maxlat", 128'(max_lat), 128'(1));

    // Run B: 8 transactions, echo
    start_run(16'd8, 3'd0);
    wait_done(40);
    check("b_grants", 128'(grants.size()), 128'(8));
    for (int i = 0; i < 8 && i < grants.size(); i++) check("b_tag", 128'(grants[i]), 128'(i));
    check("b_issued", 128'(issued), 128'(8));
    check("b_err", 128'(err_cnt), 128'(0));
    check("b_maxlat", 128'(max_lat), 128'(1));
    check("b_busy", 128'(busy), 128'(0));

    // Run D: wrong tag with latency 3, then a spurious response
    echo_en = 1'b0;
    rvalid = 1'b0;
    start_run(16'd1, 3'd0);
    cyc();
    gnt = 1'b0;
    cyc();
    cyc();
    rvalid = 1'b1; rtag = 4'd3;
    cyc();
    rvalid = 1'b0;
    cyc();
    rvalid = 1'b1; rtag = 4'd0;
    cyc();
    rvalid = 1'b0;
    cyc();
    check("d_err", 128'(err_cnt), 128'(2));
    check("d_maxlat", 128'(max_lat), 128'(3));
    check("d_done", 128'(done), 128'(1));

    // Run C: no responses, outstanding limit
    gnt = 1'b1;
    start_run(16'd5, 3'd5);
    repeat (8) cyc();
    check("c_grants4", 128'(grants.size()), 128'(4));
    check("c_req_full", 128'(req), 128'(0));
    rvalid = 1'b1; rtag = 4'd0;
    cyc();
    rvalid = 1'b0;
    repeat (4) cyc();
    check("c_grants5", 128'(grants.size()), 128'(5));
    check("c_issued", 128'(issued), 128'(5));
    check("c_err", 128'(err_cnt), 128'(0));
    repeat (20) cyc();
    check("c_drain_wait", 128'(busy), 128'(1));
    check("c_no_timeout", 128'(timeout), 128'(0));

    // Asynchronous reset mid-drain
    rst_n = 1'b0;
    #1;
    check("mr_busy_done", 128'({busy, done, req}), 128'(0));
    check("mr_counters", 128'({issued, err_cnt, max_lat}), 128'(0));
    check("mr_op", 128'(op_out), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Run E: tag wrap, start ignored while busy; LFSRs back at their seeds
    echo_en = 1'b1;
    start_run(16'd20, 3'd0);
    check("e_seed_ops", 128'(operands), 128'({32'h908FE146, 32'h32D66B8D, 32'hACE11234}));
    repeat (5) cyc();
    num_trans = 16'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(80);
    check("e_grants", 128'(grants.size()), 128'(20));
    if (grants.size() == 20) begin
      check("e_tag15", 128'(grants[15]), 128'(15));
      check("e_tag16", 128'(grants[16]), 128'(0));
      check("e_tag19", 128'(grants[19]), 128'(3));
    end
    check("e_issued", 128'(issued), 128'(20));
    check("e_err", 128'(err_cnt), 128'(0));

    // Zero-length run
    start_run(16'd0, 3'd0);
    check("z_done", 128'(done), 128'(1));
    check("z_issued", 128'(issued), 128'(0));

`ifdef APU_STIM_TIMEOUT_EN
    echo_en = 1'b0;
    rvalid = 1'b0;
    start_run(16'd1, 3'd0);
    wait_done(1100);
    check("to_fired", 128'(timeout), 128'(1));
    start_run(16'd0, 3'd0);
    check("to_cleared", 128'(timeout), 128'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
